// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the UART command dispatcher:
// frame layout, command codes and FSM state encoding.
package sd_cmd_pkg;

    localparam int FRAME_W = 16;
    localparam int CMD_W   = 4;
    localparam int ADDR_W  = 5;

    localparam int CMD_MSB  = 11;
    localparam int CMD_LSB  = 8;
    localparam int ADDR_MSB = 4;
    localparam int ADDR_LSB = 0;

    localparam logic [CMD_W-1:0] CMD_NOP   = 4'h0;
    localparam logic [CMD_W-1:0] CMD_READ  = 4'h1;
    localparam logic [CMD_W-1:0] CMD_WRITE = 4'h2;
    localparam logic [CMD_W-1:0] CMD_START = 4'h3;
    localparam logic [CMD_W-1:0] CMD_STOP  = 4'h4;
    localparam logic [CMD_W-1:0] CMD_RESET = 4'h5;
    localparam logic [CMD_W-1:0] CMD_CALIB = 4'h6;
    localparam logic [CMD_W-1:0] CMD_MAX_DEFAULT = CMD_CALIB;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    function automatic logic [CMD_W-1:0] frame_cmd(input logic [FRAME_W-1:0] f);
        return f[CMD_MSB:CMD_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_W-1:0] f);
        return f[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Saturating wait-for-ack counter; expired holds once the
// count reaches TIMEOUT_CYCLES-1 and never wraps.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/cmd_dispatcher.sv
// Routes 16-bit UART command frames to one of NUM_SENSORS
// controllers over a one-hot valid/ack handshake.
module cmd_dispatcher #(
    parameter int         NUM_SENSORS    = 8,
    parameter logic [3:0] CMD_MAX        = 4'h6,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_rx_done,
    input  logic [15:0]            uart_rx_data,
    input  logic [NUM_SENSORS-1:0] cmd_ack,
    output logic [NUM_SENSORS-1:0] cmd_valid,
    output logic [3:0]             cmd_out,
    output logic                   busy,
    output logic                   err_addr,
    output logic                   err_cmd,
    output logic                   err_timeout,
    output logic                   overrun,
    output logic [1:0]             state
);

    import sd_cmd_pkg::*;

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_SENSORS);

    state_t               state_q;
    state_t               state_d;
    logic                 pend_q;
    logic [FRAME_W-1:0]   pend_data_q;
    logic [FRAME_W-1:0]   frame_q;

    logic [NUM_SENSORS-1:0] valid_d;
    logic [CMD_W-1:0]       cmd_d;
    logic                   err_addr_d;
    logic                   err_cmd_d;
    logic                   err_timeout_d;
    logic                   latch;
    logic                   tmr_clear;
    logic                   tmr_en;
    logic                   expired;

    logic [ADDR_W-1:0] addr;
    logic [CMD_W-1:0]  cmd;
    logic              addr_bad;
    logic              cmd_bad;
    logic              acked;
    logic              accept;
    logic              unused_bits;

    assign addr     = frame_addr(frame_q);
    assign cmd      = frame_cmd(frame_q);
    assign addr_bad = ({1'b0, addr} >= ADDR_LIMIT);
    assign cmd_bad  = (cmd > CMD_MAX);
    // cmd_valid is one-hot on the latched address, so masking
    // with it observes only that sensor's ack bit.
    assign acked    = |(cmd_ack & cmd_valid);

    // A pending frame counts as in flight, so a second pulse is dropped.
    assign accept = uart_rx_done && (state_q == ST_IDLE) && !pend_q;

    assign unused_bits = ^{frame_q[15:12], frame_q[7:5]};

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expired(expired)
    );

    always_comb begin
        state_d       = state_q;
        valid_d       = cmd_valid;
        cmd_d         = cmd_out;
        err_addr_d    = 1'b0;
        err_cmd_d     = 1'b0;
        err_timeout_d = 1'b0;
        latch         = 1'b0;
        tmr_clear     = 1'b0;
        tmr_en        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    latch   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (addr_bad) begin
                    state_d    = ST_ERROR;
                    err_addr_d = 1'b1;
                end else if (cmd_bad) begin
                    state_d   = ST_ERROR;
                    err_cmd_d = 1'b1;
                end else begin
                    state_d   = ST_WAIT_ACK;
                    valid_d   = NUM_SENSORS'(1) << addr;
                    cmd_d     = cmd;
                    tmr_clear = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                tmr_en = 1'b1;
                if (acked) begin
                    valid_d = '0;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    valid_d       = '0;
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_valid   <= '0;
            cmd_out     <= '0;
            busy        <= 1'b0;
            err_addr    <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid   <= valid_d;
            cmd_out     <= cmd_d;
            busy        <= (state_d != ST_IDLE);
            err_addr    <= err_addr_d;
            err_cmd     <= err_cmd_d;
            err_timeout <= err_timeout_d;
            overrun     <= uart_rx_done && !accept;
            pend_q      <= accept;
            if (accept) begin
                pend_data_q <= uart_rx_data;
            end
            if (latch) begin
                frame_q <= pend_data_q;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher with a 16-cycle ack timeout.
module tb_cmd_dispatcher;

    logic       clk;
    logic       rst;
    logic       uart_rx_done;
    logic [15:0] uart_rx_data;
    logic [7:0] cmd_ack;
    logic [7:0] cmd_valid;
    logic [3:0] cmd_out;
    logic       busy;
    logic       err_addr;
    logic       err_cmd;
    logic       err_timeout;
    logic       overrun;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    cmd_dispatcher #(
        .NUM_SENSORS   (8),
        .CMD_MAX       (4'h6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_done(uart_rx_done),
        .uart_rx_data(uart_rx_data),
        .cmd_ack     (cmd_ack),
        .cmd_valid   (cmd_valid),
        .cmd_out     (cmd_out),
        .busy        (busy),
        .err_addr    (err_addr),
        .err_cmd     (err_cmd),
        .err_timeout (err_timeout),
        .overrun     (overrun),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses uart_rx_done across one edge (edge N); returns #1 after N.
    task automatic send(input logic [15:0] f);
        uart_rx_done = 1'b1;
        uart_rx_data = f;
        tick();
        uart_rx_done = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        uart_rx_done = 1'b0;
        uart_rx_data = 16'h0000;
        cmd_ack      = 8'h00;
        tick(2);
        rst = 1'b0;

        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(cmd_valid), 32'h00);
        chk("rst_cmd_out", 32'(cmd_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_errs", 32'({err_addr, err_cmd, err_timeout, overrun}), 32'h0);

        // Normal dispatch, ack two cycles after valid
        send(16'h0203);
        chk("t1_n0_state", 32'(state), 32'd0);
        tick();
        chk("t1_n1_state", 32'(state), 32'd1);
        chk("t1_n1_valid", 32'(cmd_valid), 32'h00);
        tick();
        chk("t1_n2_valid", 32'(cmd_valid), 32'h08);
        chk("t1_n2_cmd", 32'(cmd_out), 32'h2);
        chk("t1_n2_state", 32'(state), 32'd2);
        chk("t1_n2_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_n3_valid", 32'(cmd_valid), 32'h08);
        cmd_ack = 8'h08;
        tick();
        cmd_ack = 8'h00;
        chk("t1_ack_valid", 32'(cmd_valid), 32'h00);
        chk("t1_ack_state", 32'(state), 32'd0);
        chk("t1_ack_busy", 32'(busy), 32'd0);

        // Bad address
        send(16'h0109);
        tick(2);
        chk("t2a_err_addr", 32'(err_addr), 32'd1);
        chk("t2a_state", 32'(state), 32'd3);
        chk("t2a_valid", 32'(cmd_valid), 32'h00);
        tick();
        chk("t2a_err_addr_off", 32'(err_addr), 32'd0);
        chk("t2a_idle", 32'(state), 32'd0);

        // Bad command, legal address
        send(16'h0F01);
        tick(2);
        chk("t2b_err_cmd", 32'(err_cmd), 32'd1);
        chk("t2b_no_err_addr", 32'(err_addr), 32'd0);
        chk("t2b_valid", 32'(cmd_valid), 32'h00);
        tick();
        chk("t2b_err_cmd_off", 32'(err_cmd), 32'd0);
        chk("t2b_idle", 32'(state), 32'd0);

        // Address boundary: 8 is the first illegal address
        send(16'h0008);
        tick(2);
        chk("t2c_addr8", 32'({err_addr, err_cmd}), 32'b10);
        tick();

        // Command boundary: 7 is the first illegal code
        send(16'h0700);
        tick(2);
        chk("t2d_cmd7", 32'({err_addr, err_cmd}), 32'b01);
        tick();

        // Highest legal addr/cmd with reserved bits all set
        send(16'hF6E7);
        tick(2);
        chk("t2e_valid", 32'(cmd_valid), 32'h80);
        chk("t2e_cmd", 32'(cmd_out), 32'h6);
        cmd_ack = 8'h80;
        tick();
        cmd_ack = 8'h00;
        chk("t2e_idle", 32'(state), 32'd0);

        // Timeout after 16 WAIT_ACK cycles
        send(16'h0100);
        tick(2);
        chk("t3_valid", 32'(cmd_valid), 32'h01);
        chk("t3_cmd", 32'(cmd_out), 32'h1);
        tick(15);
        chk("t3_pre_to", 32'(err_timeout), 32'd0);
        chk("t3_pre_state", 32'(state), 32'd2);
        chk("t3_pre_valid", 32'(cmd_valid), 32'h01);
        tick();
        chk("t3_to", 32'(err_timeout), 32'd1);
        chk("t3_to_valid", 32'(cmd_valid), 32'h00);
        chk("t3_to_state", 32'(state), 32'd0);
        tick();
        chk("t3_to_off", 32'(err_timeout), 32'd0);

        // Overrun during WAIT_ACK
        send(16'h0100);
        tick(2);
        uart_rx_done = 1'b1;
        uart_rx_data = 16'h0505;
        tick();
        uart_rx_done = 1'b0;
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_valid", 32'(cmd_valid), 32'h01);
        chk("t4_cmd", 32'(cmd_out), 32'h1);
        tick();
        chk("t4_overrun_off", 32'(overrun), 32'd0);
        chk("t4_valid_held", 32'(cmd_valid), 32'h01);
        cmd_ack = 8'h01;
        tick();
        cmd_ack = 8'h00;
        tick(2);
        chk("t4_dropped_state", 32'(state), 32'd0);
        chk("t4_dropped_valid", 32'(cmd_valid), 32'h00);

        // Back-to-back pulses: second frame is dropped
        send(16'h0202);
        send(16'h0404);
        chk("t4b_overrun", 32'(overrun), 32'd1);
        tick();
        chk("t4b_valid", 32'(cmd_valid), 32'h04);
        chk("t4b_cmd", 32'(cmd_out), 32'h2);
        cmd_ack = 8'h04;
        tick();
        cmd_ack = 8'h00;

        // Reset mid-handshake
        send(16'h0100);
        tick(3);
        chk("t5_pre_valid", 32'(cmd_valid), 32'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 32'(cmd_valid), 32'h00);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_state", 32'(state), 32'd0);
        send(16'h0203);
        tick(2);
        chk("t5_redispatch", 32'(cmd_valid), 32'h08);
        cmd_ack = 8'h08;
        tick();
        cmd_ack = 8'h00;

        // Ack on the exact timeout cycle wins
        send(16'h0100);
        tick(17);
        chk("t6a_pre_valid", 32'(cmd_valid), 32'h01);
        cmd_ack = 8'h01;
        tick();
        cmd_ack = 8'h00;
        chk("t6a_no_to", 32'(err_timeout), 32'd0);
        chk("t6a_valid", 32'(cmd_valid), 32'h00);
        chk("t6a_idle", 32'(state), 32'd0);

        // Acks on other indices are ignored
        send(16'h0100);
        tick(2);
        cmd_ack = 8'hFE;
        tick(15);
        chk("t6b_held", 32'(cmd_valid), 32'h01);
        chk("t6b_state", 32'(state), 32'd2);
        tick();
        chk("t6b_to", 32'(err_timeout), 32'd1);
        chk("t6b_valid", 32'(cmd_valid), 32'h00);
        cmd_ack = 8'h00;
        tick();
        chk("t6b_to_off", 32'(err_timeout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
